// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered before the ALU; the result is held until the winner consumes it.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [WIDTH-1:0] req0_in2,
    input  logic [OPW-1:0]   req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [WIDTH-1:0] req1_in2,
    input  logic [OPW-1:0]   req1_op,

    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_out,
    output logic             resp_zero,

    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] in1_reg;
    logic [WIDTH-1:0] in2_reg;
    logic [OPW-1:0]   op_reg;
    logic [WIDTH-1:0] resp_out_reg;
    logic             resp_zero_reg;
    logic             grant_reg;
    logic             last_grant_reg;

    logic             winner;
    logic             accept;

    // With both requesting, the one not served last wins; otherwise the sole requester.
    always_comb begin
        if (req0_valid && req1_valid) begin
            winner = ~last_grant_reg;
        end else begin
            winner = req1_valid;
        end
    end

    always_comb begin
        state_next  = state_reg;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        accept      = 1'b0;
        case (state_reg)
            IDLE: begin
                // Handshakes are suppressed while reset is held so nothing appears accepted.
                req0_ready = reset && req0_valid && !winner;
                req1_ready = reset && req1_valid && winner;
                accept     = req0_ready || req1_ready;
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                resp0_valid = reset && !grant_reg;
                resp1_valid = reset && grant_reg;
                if (grant_reg ? resp1_ready : resp0_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            in1_reg        <= '0;
            in2_reg        <= '0;
            op_reg         <= '0;
            resp_out_reg   <= '0;
            resp_zero_reg  <= 1'b0;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                in1_reg        <= winner ? req1_in1 : req0_in1;
                in2_reg        <= winner ? req1_in2 : req0_in2;
                op_reg         <= winner ? req1_op  : req0_op;
                grant_reg      <= winner;
                last_grant_reg <= winner;
            end
            if (state_reg == EXEC) begin
                resp_out_reg  <= alu_out;
                resp_zero_reg <= alu_zero;
            end
        end
    end

    assign alu_in1   = in1_reg;
    assign alu_in2   = in2_reg;
    assign alu_op    = op_reg;
    assign resp_out  = resp_out_reg;
    assign resp_zero = resp_zero_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational ALU (ports in1, in2, OP, zero, out) between two requesters, e.g. the main datapath and a debug/self-test port. Runs a round-robin arbiter with valid/ready handshakes on both sides. Operands and opcode are registered before driving the ALU. The ALU result is captured and held until the winning requester consumes it.

Parameters:
WIDTH, 32, operand/result width; must match ALU in1/in2/out.
OPW, 4, opcode width; must match ALU OP.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  arbiter accepts requester 0 this cycle.
req0_in1  input  WIDTH  requester 0 operand A.
req0_in2  input  WIDTH  requester 0 operand B.
req0_op  input  OPW  requester 0 ALU opcode.
req1_valid, req1_ready, req1_in1, req1_in2, req1_op  same as requester 0, for requester 1.
resp0_valid  output  1  result for requester 0 is held.
resp0_ready  input  1  requester 0 consumes the result.
resp1_valid  output  1  result for requester 1 is held.
resp1_ready  input  1  requester 1 consumes the result.
resp_out  output  WIDTH  held ALU result, shared by both response channels.
resp_zero  output  1  held ALU zero flag.
alu_in1  output  WIDTH  to ALU in1.
alu_in2  output  WIDTH  to ALU in2.
alu_op  output  OPW  to ALU OP.
alu_out  input  WIDTH  from ALU out.
alu_zero  input  1  from ALU zero.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, EXEC, RESP. On reset the block enters IDLE and sets:
  - operand/op registers = 0; resp_out = 0, resp_zero = 0;
  - all valid/ready outputs = 0, busy = 0;
  - last_grant = 1, so requester 0 has priority first.
- alu_in1/alu_in2/alu_op always equal the operand/op registers. They are never combinational from the req ports.
- IDLE, arbitration:
  - Only one valid request: that requester wins.
  - Both valid: the requester != last_grant wins.
  - reqN_ready = (state==IDLE) && reqN_valid && (winner==N). Ready is combinational, and at most one is high.
- Accept (valid & ready):
  - latch in1/in2/op and the grant id;
  - last_grant <= N;
  - next state EXEC.
- EXEC, one cycle:
  - the ALU settles on the registered operands;
  - resp_out <= alu_out, resp_zero <= alu_zero at the end of the cycle;
  - next state RESP.
- RESP:
  - respN_valid = 1 only for the granted requester; resp_out/resp_zero are stable;
  - respN_ready high for the granted N: next state IDLE, respN_valid drops next cycle;
  - the other requester's resp_ready is ignored.
- Latency: accept at edge T, EXEC through T+1, respN_valid high from T+2. Minimum issue interval is 3 cycles, with no overlap of operations.
- No request is accepted in EXEC or RESP (both ready = 0). A requester holds valid and operands stable until ready; a request withdrawn before acceptance is never executed.
- resp_ready is allowed to be high before resp_valid. When it is, the handshake completes in the first RESP cycle.
- The opcode is passed through unchecked. Undefined opcodes return whatever the ALU produces.
- Reset mid-operation (EXEC or RESP):
  - the transaction is discarded, with no response issued;
  - all registers return to reset values;
  - last_grant = 1.
- Operand registers keep their last values in IDLE, so ALU inputs do not toggle while idle.

Test Plan:
- Reset release:
  - reset=0 for 2 cycles -> busy=0, all ready/valid=0, alu_in1=alu_in2=0, alu_op=0.
  - Then release and hold req0_valid=1 (in1=3, in2=5, op=0 add) -> req0_ready=1 in the first IDLE cycle.
  - resp0_valid exactly 2 cycles after accept, resp_out=8, resp_zero=0.
- Zero flag: req1 in1=5, in2=5, op=1 (sub), resp1_ready=1 -> resp_out=0, resp_zero=1, resp1_valid for one cycle, resp0_valid stays 0.
- Round-robin:
  - req0 and req1 held valid continuously, resp_ready tied 1 -> grants alternate 0,1,0,1.
  - Each response is 3 cycles apart.
  - The first grant after reset goes to requester 0.
- Backpressure:
  - Hold resp0_ready=0 for 5 cycles after resp0_valid -> resp0_valid, resp_out and busy stay stable.
  - req1_ready stays 0 the whole time.
  - Raise resp0_ready -> IDLE next cycle, then req1 is accepted.
- Reset mid-operation: assert reset=0 during EXEC of req0 (in1=1, in2=5, op=2) -> no resp0_valid ever appears, outputs return to reset values, and the next concurrent request grants requester 0.
- Withdrawal: req1_valid pulses while busy and drops before IDLE -> req1 is never accepted, and no resp1_valid appears.
